// File: rtl/l1a_lct_event_logger.sv
// l1a_lct_event_logger: timestamps L1A/LCT activity and buffers it in a FIFO for readback
module l1a_lct_event_logger #(
    parameter int TS_WIDTH   = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int OVF_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  l1a,
    input  logic [7:0]            lct,
    input  logic                  rd_en,
    output logic [TS_WIDTH+8:0]   dout,
    output logic                  dout_valid,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic [OVF_WIDTH-1:0]  ovf_cnt
);
    localparam int DW = TS_WIDTH + 9;
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [OVF_WIDTH-1:0]  ovf_q, ovf_d;
    logic [DW-1:0]         dout_q, dout_d;
    logic                  empty_q, full_q, dout_valid_q;
    logic                  ev, rd, wr, drop;
    logic [DW-1:0]         mem [2**DEPTH_LOG2];

    // Classify the cycle (capture/pop/drop) and derive next state; clr overrides everything
    always_comb begin
        ev       = en && !clr && (l1a || lct != 8'd0);
        rd       = rd_en && !clr && !empty_q;
        wr       = ev && (!full_q || rd);
        drop     = ev && full_q && !rd;
        ts_d     = clr ? '0 : ts_q + TS_WIDTH'(en);
        wr_ptr_d = clr ? '0 : wr_ptr_q + DEPTH_LOG2'(wr);
        rd_ptr_d = clr ? '0 : rd_ptr_q + DEPTH_LOG2'(rd);
        count_d  = clr ? '0 : count_q + CW'(wr) - CW'(rd);
        ovf_d    = clr ? '0 : ovf_q + OVF_WIDTH'(drop && !(&ovf_q));
        dout_d   = rd ? mem[rd_ptr_q] : dout_q;
    end

    // Control and status registers; flags are recomputed from the next count so they never lag it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= '0;
            dout_q       <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            ts_q         <= ts_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            dout_q       <= dout_d;
            empty_q      <= count_d == '0;
            full_q       <= count_d == FULL_CNT;
            dout_valid_q <= rd;
        end
    end

    // Event storage stamped with the pre-increment timestamp; a full-FIFO write lands on the slot being popped
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr_q] <= {ts_q, l1a, lct};
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign count      = count_q;
    assign ovf_cnt    = ovf_q;
endmodule

// File: tb/tb_l1a_lct_event_logger.sv
// tb_l1a_lct_event_logger: scoreboard bench for the event logger (32-bit and 4-bit timestamp instances)
module tb_l1a_lct_event_logger;
    logic        clk, rst_n, en, clr, l1a, rd_en;
    logic [7:0]  lct;
    logic [40:0] dout;
    logic        dout_valid, empty, full;
    logic [4:0]  count;
    logic [15:0] ovf_cnt;
    logic        s_en, s_clr, s_l1a, s_rd;
    logic [7:0]  s_lct;
    logic [12:0] s_dout;
    logic        s_dv, s_empty, s_full;
    logic [4:0]  s_count;
    logic [15:0] s_ovf;
    int          total = 0;
    int          bad = 0;
    logic [40:0] q[$];
    logic [12:0] sq[$];

    l1a_lct_event_logger dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .l1a(l1a), .lct(lct), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .empty(empty), .full(full), .count(count), .ovf_cnt(ovf_cnt)
    );

    l1a_lct_event_logger #(.TS_WIDTH(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(s_en), .clr(s_clr), .l1a(s_l1a), .lct(s_lct), .rd_en(s_rd),
        .dout(s_dout), .dout_valid(s_dv), .empty(s_empty), .full(s_full), .count(s_count), .ovf_cnt(s_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    // Scoreboard monitors: every valid output word must match the oldest expected word
    always @(negedge clk) begin
        if (rst_n && dout_valid) begin
            logic [40:0] e;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL dout_unexpected: got %h, expected no valid word", dout);
            end else begin
                e = q.pop_front();
                if (dout !== e) begin
                    bad++;
                    $display("FAIL dout_word: got %h, expected %h", dout, e);
                end
            end
        end
        if (rst_n && s_dv) begin
            logic [12:0] e;
            total++;
            if (sq.size() == 0) begin
                bad++;
                $display("FAIL s_dout_unexpected: got %h, expected no valid word", s_dout);
            end else begin
                e = sq.pop_front();
                if (s_dout !== e) begin
                    bad++;
                    $display("FAIL s_dout_word: got %h, expected %h", s_dout, e);
                end
            end
        end
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", n, a, e);
        end
    endtask

    task automatic tick(input logic e, input logic l, input logic [7:0] c, input logic r);
        en = e; l1a = l; lct = c; rd_en = r;
        @(posedge clk);
        #1;
    endtask

    task automatic stick(input logic e, input logic l, input logic [7:0] c, input logic r);
        s_en = e; s_l1a = l; s_lct = c; s_rd = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; en = 0; clr = 0; l1a = 0; lct = 0; rd_en = 0;
        s_en = 0; s_clr = 0; s_l1a = 0; s_lct = 0; s_rd = 0;
        #2 rst_n = 1'b0;
        #6;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_ovf", ovf_cnt, 0);
        #12 rst_n = 1'b1;
        // l1a at ts=3, lct=05 at ts=7
        for (int i = 0; i < 10; i++) begin
            if (i == 3) q.push_back({32'd3, 1'b1, 8'h00});
            if (i == 7) q.push_back({32'd7, 1'b0, 8'h05});
            tick(1'b1, i == 3, (i == 7) ? 8'h05 : 8'h00, 1'b0);
        end
        chk("t1_count", count, 2);
        tick(0, 0, 8'h00, 1);
        tick(0, 0, 8'h00, 1);
        chk("t1_empty", empty, 1);
        // combined l1a + lct at ts=0x20
        repeat (22) tick(1, 0, 8'h00, 0);
        q.push_back({32'h20, 1'b1, 8'h81});
        tick(1, 1, 8'h81, 0);
        chk("t2_count", count, 1);
        tick(0, 0, 8'h00, 1);
        // flush, then fill 16 and overflow by 3
        clr = 1'b1;
        tick(1, 1, 8'hFF, 1);
        clr = 1'b0;
        chk("t3_clr_count", count, 0);
        for (int i = 0; i < 16; i++) begin
            q.push_back({32'(i), 1'b0, 8'h01});
            tick(1, 0, 8'h01, 0);
        end
        repeat (3) tick(1, 0, 8'h01, 0);
        chk("t3_full", full, 1);
        chk("t3_count", count, 16);
        chk("t3_ovf", ovf_cnt, 3);
        // full with simultaneous write and pop
        q.push_back({32'd19, 1'b0, 8'h02});
        tick(1, 0, 8'h02, 1);
        chk("t4_count", count, 16);
        chk("t4_full", full, 1);
        chk("t4_ovf", ovf_cnt, 3);
        repeat (16) tick(0, 0, 8'h00, 1);
        chk("t3_drain_empty", empty, 1);
        chk("t3_drain_count", count, 0);
        chk("t3_drain_full", full, 0);
        tick(0, 0, 8'h00, 1);
        chk("empty_rd_valid", dout_valid, 0);
        chk("empty_rd_hold", dout, {32'd19, 1'b0, 8'h02});
        // read on empty while an event is written
        q.push_back({32'd20, 1'b1, 8'h00});
        tick(1, 1, 8'h00, 1);
        chk("t5_valid", dout_valid, 0);
        chk("t5_count", count, 1);
        tick(0, 0, 8'h00, 1);
        chk("t5_valid_next", dout_valid, 1);
        chk("t5_count_next", count, 0);
        // clr mid-stream discards queued words and the overflow count
        tick(1, 0, 8'h10, 0);
        tick(1, 0, 8'h11, 0);
        chk("t6_count_pre", count, 2);
        clr = 1'b1;
        tick(1, 1, 8'h00, 1);
        clr = 1'b0;
        chk("t6_count", count, 0);
        chk("t6_ovf", ovf_cnt, 0);
        chk("t6_empty", empty, 1);
        chk("t6_valid", dout_valid, 0);
        q.push_back({32'd0, 1'b0, 8'h44});
        tick(1, 0, 8'h44, 0);
        tick(0, 0, 8'h00, 1);
        // 4-bit timestamp wrap
        repeat (15) stick(1, 0, 8'h00, 0);
        sq.push_back({4'hF, 1'b0, 8'h01});
        stick(1, 0, 8'h01, 0);
        sq.push_back({4'h0, 1'b1, 8'h00});
        stick(1, 1, 8'h00, 0);
        chk("wrap_count", s_count, 2);
        stick(0, 0, 8'h00, 1);
        stick(0, 0, 8'h00, 1);
        stick(0, 0, 8'h00, 0);
        tick(0, 0, 8'h00, 0);
        chk("q_left", q.size(), 0);
        chk("sq_left", sq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/l1a_lct_event_logger.md
Name: l1a_lct_event_logger

Overview:
- Capture-side counterpart to the timestamped L1A/LCT stimulus source.
- Watches the `l1a` and `lct[7:0]` strobes and keeps a free-running timestamp counter.
- Each cycle with activity is packed as {timestamp, l1a, lct} and written into an internal FIFO.
- Packed words are read out with a read-enable/valid handshake, for readback to the control path or for dumping to a file in simulation.

Parameters:
- TS_WIDTH, 32: timestamp counter width.
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 words (16).
- OVF_WIDTH, 16: width of the saturating overflow counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  enables timestamp counting and event capture.
- clr  input  1  synchronous flush: clears FIFO, timestamp and overflow counter.
- l1a  input  1  L1A strobe being monitored.
- lct  input  8  LCT bits being monitored.
- rd_en  input  1  read request; pops one word when not empty.
- dout  output  TS_WIDTH+9  read word = {ts[TS_WIDTH-1:0], l1a, lct[7:0]}.
- dout_valid  output  1  one-cycle pulse, qualifies `dout`.
- empty  output  1  FIFO holds 0 words.
- full  output  1  FIFO holds 2**DEPTH_LOG2 words.
- count  output  DEPTH_LOG2+1  FIFO occupancy.
- ovf_cnt  output  OVF_WIDTH  number of dropped events, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ts=0, rd/wr pointers=0, count=0, empty=1, full=0.
  - dout=0, dout_valid=0, ovf_cnt=0.
- Timestamp:
  - `ts` increments by 1 on each clk with en=1 and clr=0; it holds when en=0.
  - Wraps from all-ones to 0 with no flag.
- Event detect: a cycle with en=1, clr=0 and (l1a=1 or lct!=0).
- Event capture:
  - The written word uses `ts` as registered in that same cycle (pre-increment value), plus the sampled l1a and lct.
  - The first enabled cycle after reset is therefore stamped 0.
  - No latency between strobe and capture beyond the FIFO write edge.
  - The word is visible to a read on the next cycle.
- Write rules:
  - Not full: write, count+1.
  - Full and no pop in the same cycle: event dropped, ovf_cnt+1, saturating at all-ones.
  - Full with a pop in the same cycle: write accepted, count unchanged, no overflow.
- Read rules:
  - rd_en=1 with count>0 at the edge: `dout` is registered from the read pointer, dout_valid=1 for exactly one cycle, pointer advances, count-1.
  - rd_en while empty: ignored; dout_valid=0 and `dout` holds its previous value.
  - Simultaneous write and rd_en while empty: the read is ignored and the write proceeds (no write-to-read bypass).
  - Back-to-back rd_en drains one word per cycle.
- Pointers: wrap modulo 2**DEPTH_LOG2.
  - full = (count == 2**DEPTH_LOG2).
  - empty = (count == 0).
  - Both are registered and consistent with `count` in the same cycle.
- clr (synchronous, highest priority after rst_n):
  - Next edge: pointers=0, count=0, ts=0, ovf_cnt=0, dout_valid=0.
  - Any event or read in that cycle is discarded; `dout` holds.
- en=0: no capture and no timestamp advance; reads continue to work.
- Reset mid-operation: all state returns immediately to reset values; FIFO contents are treated as lost.

Test Plan:
- Reset, en=1 for 10 cycles, l1a=1 in cycle 3 (ts=3), lct=8'h05 in cycle 7 -> after a read burst, two pulses with dout={32'h3,1,8'h00} then {32'h7,0,8'h05}.
- Simultaneous l1a=1 and lct=8'h81 at ts=0x20 -> a single word {32'h20,1,8'h81}; count=1.
- Fill with 16 events and no reads, then 3 more events -> full=1, count=16, ovf_cnt=3; drain 16 reads returns the first 16 timestamps in order, then empty=1.
- Full FIFO, event and rd_en in the same cycle -> count stays 16, ovf_cnt unchanged; the new word is the last read back.
- rd_en on an empty FIFO while an event is written -> no dout_valid that cycle, count=1; rd_en next cycle returns the event.
- Timestamp wrap with TS_WIDTH=4 and events at ts=15 and the following cycle -> words stamped 4'hF and 4'h0. Separately, clr mid-stream -> count=0, ovf_cnt=0, and the next event is stamped 0.
